// File: rtl/rgb_pwm_meter.sv
// rgb_pwm_meter: measures per-channel on-time of three LED drive lines over a fixed window.
// Ports: clk, rst_n (async assert, sync release); led_in {b,g,r} asynchronous lines;
//   duty_r/g/b on-cycles of last published window; duty_valid/duty_ready handshake;
//   overrun sticky flag for a window that completed while the previous result was unconsumed.
// Option: RGB_PWM_METER_EDGE_COUNT_EN adds edges_r/g/b, rising on-transitions per window.
module rgb_pwm_meter #(
  parameter int unsigned PERIOD = 256,
  parameter int unsigned CNT_W = 9,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       led_in,
  output logic [CNT_W-1:0] duty_r,
  output logic [CNT_W-1:0] duty_g,
  output logic [CNT_W-1:0] duty_b,
  output logic             duty_valid,
  input  logic             duty_ready,
  output logic             overrun
`ifdef RGB_PWM_METER_EDGE_COUNT_EN
  ,
  output logic [CNT_W-1:0] edges_r,
  output logic [CNT_W-1:0] edges_g,
  output logic [CNT_W-1:0] edges_b
`endif
);
  localparam int WC_W = $clog2(PERIOD);
  typedef enum logic {SYNC, MEASURE} state_t;
  state_t state;
  logic rst_s;
  logic sc;
  logic [2:0] s1, s2, on;
  logic [WC_W-1:0] wcnt;
  logic [2:0][CNT_W-1:0] acc, tot, duty;
  logic wend, load;
  assign on = s2 ^ {3{ACTIVE_LOW}};
  assign wend = (state == MEASURE) && (wcnt == WC_W'(PERIOD - 1));
  // the window-end sample is part of the published total
  assign load = wend && (!duty_valid || duty_ready);
  assign duty_r = duty[0];
  assign duty_g = duty[1];
  assign duty_b = duty[2];
  always_comb begin
    for (int i = 0; i < 3; i++) tot[i] = acc[i] + CNT_W'(on[i]);
  end
`ifdef RGB_PWM_METER_EDGE_COUNT_EN
  logic [2:0] prev;
  logic [2:0][CNT_W-1:0] ecnt, etot, edges;
  assign edges_r = edges[0];
  assign edges_g = edges[1];
  assign edges_b = edges[2];
  always_comb begin
    for (int i = 0; i < 3; i++) etot[i] = ecnt[i] + CNT_W'(on[i] & ~prev[i]);
  end
  // edge history runs through window boundaries so a rise on the first sample still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= '0;
      ecnt  <= '0;
      edges <= '0;
    end else if (rst_s) begin
      prev <= on;
      if (state == MEASURE) begin
        for (int i = 0; i < 3; i++) ecnt[i] <= wend ? '0 : etot[i];
        if (load) edges <= etot;
      end
    end
  end
`endif
  // rst_s delays release by one edge so every register leaves reset on the same clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_s      <= 1'b0;
      state      <= SYNC;
      sc         <= 1'b0;
      s1         <= '0;
      s2         <= '0;
      wcnt       <= '0;
      acc        <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (!rst_s) begin
      rst_s <= 1'b1;
    end else begin
      s1 <= led_in;
      s2 <= s1;
      if (state == SYNC) begin
        sc <= 1'b1;
        if (sc) state <= MEASURE;
      end else begin
        wcnt <= wend ? '0 : wcnt + 1'b1;
        for (int i = 0; i < 3; i++) acc[i] <= wend ? '0 : tot[i];
        if (load) begin
          duty       <= tot;
          duty_valid <= 1'b1;
        end else if (wend) overrun <= 1'b1;
        else if (duty_ready) duty_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rgb_pwm_meter.sv
// tb_rgb_pwm_meter: randomized self-checking bench for rgb_pwm_meter against a window-sum model.
module tb_rgb_pwm_meter;
  localparam int P = 16;
  localparam int CW = 5;
  localparam bit AL = 1'b1;
`ifdef RGB_PWM_METER_EDGE_COUNT_EN
  localparam int W = 2 + 6 * CW;
`else
  localparam int W = 2 + 3 * CW;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] led_in = 3'b000;
  logic duty_ready = 1'b0;
  logic [CW-1:0] duty_r, duty_g, duty_b, a0_r, a0_g, a0_b;
  logic duty_valid, overrun, a0_valid, a0_ovr;
  int checks = 0;
  int failures = 0;
  int n = 0;
  logic [2:0] hist[$];
  logic m_valid = 1'b0;
  logic m_ovr = 1'b0;
  logic [CW-1:0] m_duty[3] = '{default: '0};
  logic [CW-1:0] m_edge[3] = '{default: '0};
  logic [W-1:0] got, exp;
  always #5 clk = ~clk;
`ifdef RGB_PWM_METER_EDGE_COUNT_EN
  logic [CW-1:0] edges_r, edges_g, edges_b, e0_r, e0_g, e0_b;
  assign got = {duty_valid, overrun, duty_r, duty_g, duty_b, edges_r, edges_g, edges_b};
  assign exp = {m_valid, m_ovr, m_duty[0], m_duty[1], m_duty[2], m_edge[0], m_edge[1], m_edge[2]};
  rgb_pwm_meter #(.PERIOD(P), .CNT_W(CW), .ACTIVE_LOW(AL)) dut (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .overrun(overrun),
    .edges_r(edges_r), .edges_g(edges_g), .edges_b(edges_b));
  rgb_pwm_meter #(.PERIOD(P), .CNT_W(CW), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .duty_r(a0_r), .duty_g(a0_g), .duty_b(a0_b),
    .duty_valid(a0_valid), .duty_ready(duty_ready), .overrun(a0_ovr),
    .edges_r(e0_r), .edges_g(e0_g), .edges_b(e0_b));
`else
  assign got = {duty_valid, overrun, duty_r, duty_g, duty_b};
  assign exp = {m_valid, m_ovr, m_duty[0], m_duty[1], m_duty[2]};
  rgb_pwm_meter #(.PERIOD(P), .CNT_W(CW), .ACTIVE_LOW(AL)) dut (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .overrun(overrun));
  rgb_pwm_meter #(.PERIOD(P), .CNT_W(CW), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .duty_r(a0_r), .duty_g(a0_g), .duty_b(a0_b),
    .duty_valid(a0_valid), .duty_ready(duty_ready), .overrun(a0_ovr));
`endif

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n = 0;
    hist.delete();
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_duty = '{default: '0};
    m_edge = '{default: '0};
  endtask

  // One clock: drive inputs, then advance the model by the edge that follows.
  // Window w sums the line values driven before edges 1+P*w .. P+P*w after release
  // and publishes on edge 19+P*w-P+... i.e. edge 3+P*(w+1).
  task automatic step(input logic [2:0] led, input logic rdy);
    int w, t, e;
    logic on, pv;
    @(negedge clk);
    rst_n = 1'b1;
    led_in = led;
    duty_ready = rdy;
    // the first value after release is seen while the synchronizer is still cleared
    hist.push_back(n == 0 ? 3'b000 : led);
    @(posedge clk);
    n++;
    if (n >= 4 && (n - 4) % P == P - 1) begin
      w = (n - 4) / P;
      if (!m_valid || rdy) begin
        for (int c = 0; c < 3; c++) begin
          t = 0;
          e = 0;
          for (int i = 1 + P * w; i <= P + P * w; i++) begin
            on = hist[i][c] ^ AL;
            pv = hist[i-1][c] ^ AL;
            t += int'(on);
            e += int'(on && !pv);
          end
          m_duty[c] = CW'(t);
          m_edge[c] = CW'(e);
        end
        m_valid = 1'b1;
      end else m_ovr = 1'b1;
    end else if (m_valid && rdy) m_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({got, a0_valid, a0_ovr, a0_r, a0_g, a0_b} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", got);
    end
    for (int k = 1; k <= 19; k++) begin
      step(3'b000, 1'b0);
      checks++;
      if (k < 19 && duty_valid !== 1'b0) begin
        failures++;
        $display("FAIL early_valid cycle=%0d got=%b exp=0", k, duty_valid);
      end
    end
    checks++;
    if ({duty_valid, overrun, duty_r, duty_g, duty_b} !== {1'b1, 1'b0, CW'(16), CW'(16), CW'(16)}) begin
      failures++;
      $display("FAIL first_result got=%b %b %0d %0d %0d exp=1 0 16 16 16", duty_valid, overrun, duty_r, duty_g, duty_b);
    end
    checks++;
    if ({a0_valid, a0_r, a0_g, a0_b} !== {1'b1, CW'(0), CW'(0), CW'(0)}) begin
      failures++;
      $display("FAIL active_high_off got=%b %0d %0d %0d exp=1 0 0 0", a0_valid, a0_r, a0_g, a0_b);
    end
  endtask

  task automatic test_all_off();
    int pulses = 0;
    do_reset();
    for (int k = 0; k < 80; k++) begin
      step(3'b111, 1'b1);
      pulses += int'(duty_valid === 1'b1);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL all_off cycle=%0d got=%h exp=%h", n, got, exp);
      end
      if (duty_valid === 1'b1) begin
        checks++;
        if ({duty_r, duty_g, duty_b} !== '0) begin
          failures++;
          $display("FAIL all_off_zero got=%0d %0d %0d exp=0", duty_r, duty_g, duty_b);
        end
      end
    end
    checks++;
    if (pulses != 4) begin
      failures++;
      $display("FAIL valid_pulses got=%0d exp=4", pulses);
    end
  endtask

  task automatic test_pattern();
    logic [2:0] v;
    do_reset();
    for (int k = 0; k < 70; k++) begin
      v = 3'($urandom);
      v[0] = (n % 4 == 1) ? 1'b0 : 1'b1;
      step(v, 1'b1);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL pattern cycle=%0d got=%h exp=%h", n, got, exp);
      end
      if (duty_valid === 1'b1) begin
        checks++;
        if (duty_r !== CW'(4)) begin
          failures++;
          $display("FAIL pattern_duty_r got=%0d exp=4", duty_r);
        end
`ifdef RGB_PWM_METER_EDGE_COUNT_EN
        if (n > 19) begin
          checks++;
          if (edges_r !== CW'(4)) begin
            failures++;
            $display("FAIL pattern_edges_r got=%0d exp=4", edges_r);
          end
        end
`endif
      end
    end
  endtask

  task automatic test_stall();
    logic [3*CW-1:0] first;
    do_reset();
    repeat (19) step(3'($urandom), 1'b0);
    first = {duty_r, duty_g, duty_b};
    for (int k = 0; k < 40; k++) begin
      step(3'($urandom), 1'b0);
      checks++;
      if (got !== exp || {duty_r, duty_g, duty_b} !== first || duty_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall cycle=%0d got=%h exp=%h held=%h", n, got, exp, first);
      end
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL stall_overrun got=%b exp=1", overrun);
    end
    repeat (3) begin
      step(3'($urandom), 1'b1);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL stall_drain cycle=%0d got=%h exp=%h", n, got, exp);
      end
    end
  endtask

  task automatic test_ready_at_end();
    do_reset();
    repeat (19) step(3'($urandom), 1'b0);
    for (int k = 0; k < 16; k++) begin
      step(3'($urandom), ((n + 1 - 4) % P) == P - 1);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL ready_end cycle=%0d got=%h exp=%h", n, got, exp);
      end
    end
    checks++;
    if ({duty_valid, overrun} !== 2'b10) begin
      failures++;
      $display("FAIL ready_end_flags got=%b%b exp=10", duty_valid, overrun);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step(3'($urandom), $urandom_range(0, 3) != 0);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random cycle=%0d got=%h exp=%h", n, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (25) step(3'($urandom), 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({got, a0_valid, a0_ovr, a0_r, a0_g, a0_b} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", got);
    end
    do_reset();
    for (int k = 1; k <= 19; k++) begin
      step(3'b000, 1'b0);
      checks++;
      if (duty_valid !== (k == 19)) begin
        failures++;
        $display("FAIL reset_mid_valid cycle=%0d got=%b exp=%b", k, duty_valid, k == 19);
      end
    end
    checks++;
    if ({duty_r, duty_g, duty_b, overrun} !== {CW'(16), CW'(16), CW'(16), 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_duty got=%0d %0d %0d %b exp=16 16 16 0", duty_r, duty_g, duty_b, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_all_off();
    test_pattern();
    test_stall();
    test_ready_at_end();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
